// File: rtl/alu_sequencer_if.sv
// Result channel from alu_sequencer to the UART response formatter.
// The sequencer is the master (drives valid/data/err); the formatter is the slave (drives ready).
interface alu_sequencer_if;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [1:0]  res_err;

  modport master (output res_valid, output res_data, output res_err, input res_ready);
  modport slave  (input res_valid, input res_data, input res_err, output res_ready);
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer: accepts one parsed command per parser_done, validates it, starts exactly
// one arithmetic unit, waits for its done and presents the result on a valid/ready channel.
// Optional build macro ALU_TIMEOUT_EN adds a WAIT-state timeout abort (res_err = 11).
module alu_sequencer #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TO_W           = 7
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic [3:0]           dtype,
  input  logic [4:0]           operator,
  input  logic [15:0]          src1,
  input  logic [15:0]          src2,
  input  logic                 parser_done,
  output logic                 busy,
  output logic                 overrun,
  output logic [3:0]           unit_start,
  output logic                 unit_signed,
  output logic [15:0]          op_a,
  output logic [15:0]          op_b,
  input  logic [3:0]           unit_done,
  input  logic [31:0]          res_add,
  input  logic [31:0]          res_sub,
  input  logic [31:0]          res_mul,
  input  logic [31:0]          res_div,
  alu_sequencer_if.master      res
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  state_t      state, state_next;
  logic [1:0]  sel;
  logic [31:0] res_data_q, res_data_next;
  logic [1:0]  res_err_q, res_err_next;
  logic        load_cmd;
  logic        cmd_legal;
  logic        div_zero;
  logic [1:0]  sel_dec;
  logic [31:0] unit_res;

  // Elaboration-time guard: the timeout counter must be able to reach TIMEOUT_CYCLES.
  if (2**TO_W <= TIMEOUT_CYCLES) begin : g_cfg_check
    $error("alu_sequencer: 2**TO_W must exceed TIMEOUT_CYCLES");
  end

`ifdef ALU_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt;

  // Timeout counter: cleared in ISSUE, counts every WAIT cycle.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)               to_cnt <= '0;
    else if (state == ISSUE)  to_cnt <= '0;
    else if (state == WAIT)   to_cnt <= to_cnt + 1'b1;
  end
`endif

  // Command decode on the live parser inputs; operator 1..4 maps to unit index 0..3.
  always_comb begin
    cmd_legal = ((dtype == 4'd1) || (dtype == 4'd2)) &&
                (operator >= 5'd1) && (operator <= 5'd4);
    div_zero  = (operator == 5'd4) && (src2 == 16'd0);
    sel_dec   = operator[1:0] - 2'd1;
  end

  // Result select for the unit that was started.
  always_comb begin
    unit_res = res_add;
    case (sel)
      2'd0: unit_res = res_add;
      2'd1: unit_res = res_sub;
      2'd2: unit_res = res_mul;
      default: unit_res = res_div;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state, result-capture values and FSM-decoded outputs.
  always_comb begin
    state_next    = state;
    res_data_next = res_data_q;
    res_err_next  = res_err_q;
    load_cmd      = 1'b0;
    unit_start    = '0;
    case (state)
      IDLE: begin
        if (parser_done) begin
          load_cmd = 1'b1;
          if (!cmd_legal) begin
            state_next    = HOLD;
            res_err_next  = 2'b01;
            res_data_next = '0;
          end else if (div_zero) begin
            state_next    = HOLD;
            res_err_next  = 2'b10;
            res_data_next = '1;
          end else begin
            state_next = ISSUE;
          end
        end
      end
      ISSUE: begin
        unit_start[sel] = 1'b1;
        state_next      = WAIT;
      end
      WAIT: begin
        if (unit_done[sel]) begin
          state_next    = HOLD;
          res_err_next  = 2'b00;
          res_data_next = unit_res;
        end
`ifdef ALU_TIMEOUT_EN
        else if (to_cnt == TO_W'(TIMEOUT_CYCLES)) begin
          state_next    = HOLD;
          res_err_next  = 2'b11;
          res_data_next = '0;
        end
`endif
      end
      HOLD: begin
        if (res.res_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Command latches, result registers and the overrun pulse.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sel         <= '0;
      unit_signed <= 1'b0;
      op_a        <= '0;
      op_b        <= '0;
      res_data_q  <= '0;
      res_err_q   <= '0;
      overrun     <= 1'b0;
    end else begin
      if (load_cmd) begin
        sel         <= sel_dec;
        unit_signed <= (dtype == 4'd1);
        op_a        <= src1;
        op_b        <= src2;
      end
      res_data_q <= res_data_next;
      res_err_q  <= res_err_next;
      overrun    <= parser_done && (state != IDLE);
    end
  end

  assign busy          = (state != IDLE);
  assign res.res_valid = (state == HOLD);
  assign res.res_data  = res_data_q;
  assign res.res_err   = res_err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: stimulus pushes expected results, a negedge monitor
// pops and compares on every accepted result. The bench also plays the arithmetic units.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        n_rst;
  logic [3:0]  dtype;
  logic [4:0]  operator;
  logic [15:0] src1, src2;
  logic        parser_done;
  logic        busy, overrun, unit_signed;
  logic [3:0]  unit_start;
  logic [15:0] op_a, op_b;
  logic [3:0]  unit_done;
  logic [31:0] res_add, res_sub, res_mul, res_div;

  alu_sequencer_if rif ();

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  alu_sequencer #(.TIMEOUT_CYCLES(64), .TO_W(7)) dut (
    .clk(clk), .n_rst(n_rst), .dtype(dtype), .operator(operator),
    .src1(src1), .src2(src2), .parser_done(parser_done),
    .busy(busy), .overrun(overrun), .unit_start(unit_start),
    .unit_signed(unit_signed), .op_a(op_a), .op_b(op_b),
    .unit_done(unit_done), .res_add(res_add), .res_sub(res_sub),
    .res_mul(res_mul), .res_div(res_div), .res(rif)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every accepted result must match the oldest expected entry.
  always @(negedge clk) begin
    if (n_rst && rif.res_valid && rif.res_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_underflow: got data %h err %b with no expected entry", rif.res_data, rif.res_err);
      end else begin
        mon_e = exp_q.pop_front();
        chk("res_data", rif.res_data, mon_e.data);
        chk("res_err", {30'd0, rif.res_err}, {30'd0, mon_e.err});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_overrun"}, {31'd0, overrun}, 32'd0);
    chk({tag, "_unit_start"}, {28'd0, unit_start}, 32'd0);
    chk({tag, "_unit_signed"}, {31'd0, unit_signed}, 32'd0);
    chk({tag, "_op_a"}, {16'd0, op_a}, 32'd0);
    chk({tag, "_op_b"}, {16'd0, op_b}, 32'd0);
    chk({tag, "_res_valid"}, {31'd0, rif.res_valid}, 32'd0);
    chk({tag, "_res_data"}, rif.res_data, 32'd0);
    chk({tag, "_res_err"}, {30'd0, rif.res_err}, 32'd0);
  endtask

  // Drive one command strobe; returns #1 after the sampling edge (cycle N+1).
  task automatic cmd(input logic [3:0] dt, input logic [4:0] op,
                     input logic [15:0] a, input logic [15:0] b);
    tick();
    dtype = dt; operator = op; src1 = a; src2 = b; parser_done = 1'b1;
    tick();
    parser_done = 1'b0;
    src1 = 16'hDEAD; src2 = 16'hBEEF; dtype = 4'hF; operator = 5'h1F;
  endtask

  // Called at N+1: check the start pulse, then return done after extra_wait more cycles.
  task automatic run_unit(input int idx, input int extra_wait, input logic [31:0] result,
                          input logic [15:0] ea, input logic [15:0] eb, input logic es,
                          input logic spurious);
    chk("unit_start", {28'd0, unit_start}, 32'd1 << idx);
    tick();
    chk("unit_start_one_cycle", {28'd0, unit_start}, 32'd0);
    chk("op_a", {16'd0, op_a}, {16'd0, ea});
    chk("op_b", {16'd0, op_b}, {16'd0, eb});
    chk("unit_signed", {31'd0, unit_signed}, {31'd0, es});
    if (spurious) unit_done = ~(4'b0001 << idx);
    for (int i = 0; i < extra_wait; i++) tick();
    unit_done = 4'b0001 << idx;
    case (idx)
      0: res_add = result;
      1: res_sub = result;
      2: res_mul = result;
      default: res_div = result;
    endcase
    tick();
    unit_done = 4'b0000;
    chk("res_valid_latency", {31'd0, rif.res_valid}, 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic pulse_reset(input string tag);
    @(posedge clk);
    #3 n_rst = 1'b0;
    #1 check_zero_outputs(tag);
    tick();
    n_rst = 1'b1;
  endtask

  initial begin
    n_rst = 1'b0; dtype = '0; operator = '0; src1 = '0; src2 = '0; parser_done = 1'b0;
    unit_done = '0; rif.res_ready = 1'b0;
    res_add = 32'hA0A0_A0A0; res_sub = 32'hB0B0_B0B0; res_mul = 32'hC0C0_C0C0; res_div = 32'hD0D0_D0D0;
    #12 check_zero_outputs("reset");
    tick();
    n_rst = 1'b1;
    tick();

    // 1: unsigned add, done two cycles after start, a stray div done must be ignored.
    rif.res_ready = 1'b1;
    exp_q.push_back('{data: 32'd7, err: 2'b00});
    cmd(4'd2, 5'd1, 16'd3, 16'd4);
    run_unit(0, 1, 32'd7, 16'd3, 16'd4, 1'b0, 1'b1);
    wait_idle("t1");

    // 2: signed multiply.
    exp_q.push_back('{data: 32'hFFFF_FFFA, err: 2'b00});
    cmd(4'd1, 5'd3, 16'hFFFE, 16'd3);
    run_unit(2, 3, 32'hFFFF_FFFA, 16'hFFFE, 16'd3, 1'b1, 1'b0);
    wait_idle("t2");

    // 3: divide by zero reports immediately without starting a unit.
    exp_q.push_back('{data: 32'hFFFF_FFFF, err: 2'b10});
    cmd(4'd2, 5'd4, 16'd9, 16'd0);
    chk("t3_unit_start", {28'd0, unit_start}, 32'd0);
    chk("t3_res_valid", {31'd0, rif.res_valid}, 32'd1);
    wait_idle("t3");

    // 3b: legal divide.
    exp_q.push_back('{data: 32'd3, err: 2'b00});
    cmd(4'd2, 5'd4, 16'd9, 16'd3);
    run_unit(3, 2, 32'd3, 16'd9, 16'd3, 1'b0, 1'b0);
    wait_idle("t3b");

    // 4: illegal dtype; strobes during HOLD and on the handshake cycle are dropped.
    rif.res_ready = 1'b0;
    exp_q.push_back('{data: 32'd0, err: 2'b01});
    cmd(4'd3, 5'd1, 16'd1, 16'd1);
    chk("t4_res_valid", {31'd0, rif.res_valid}, 32'd1);
    dtype = 4'd2; operator = 5'd1; parser_done = 1'b1;
    tick();
    parser_done = 1'b0;
    chk("t4_overrun", {31'd0, overrun}, 32'd1);
    chk("t4_no_start", {28'd0, unit_start}, 32'd0);
    tick();
    chk("t4_overrun_clear", {31'd0, overrun}, 32'd0);
    rif.res_ready = 1'b1; parser_done = 1'b1;
    tick();
    parser_done = 1'b0;
    chk("t4_overrun_hs", {31'd0, overrun}, 32'd1);
    chk("t4_busy_hs", {31'd0, busy}, 32'd0);
    tick();
    chk("t4_dropped_busy", {31'd0, busy}, 32'd0);
    chk("t4_dropped_start", {28'd0, unit_start}, 32'd0);

    // 5: consumer stalls for five cycles; result must hold.
    rif.res_ready = 1'b0;
    exp_q.push_back('{data: 32'd6, err: 2'b00});
    cmd(4'd2, 5'd2, 16'd9, 16'd3);
    run_unit(1, 1, 32'd6, 16'd9, 16'd3, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t5_valid_stable", {31'd0, rif.res_valid}, 32'd1);
      chk("t5_data_stable", rif.res_data, 32'd6);
    end
    rif.res_ready = 1'b1;
    tick();
    chk("t5_busy", {31'd0, busy}, 32'd0);
    chk("t5_valid", {31'd0, rif.res_valid}, 32'd0);

`ifdef ALU_TIMEOUT_EN
    // 6: no done ever comes; timeout abort, late done ignored.
    rif.res_ready = 1'b0;
    exp_q.push_back('{data: 32'd0, err: 2'b11});
    cmd(4'd2, 5'd1, 16'd5, 16'd5);
    begin
      int n = 0;
      while (!rif.res_valid && n < 100) begin
        tick();
        n++;
      end
      chk("t6_timeout_cycles", n, 32'd66);
    end
    res_add = 32'h1234_5678; unit_done = 4'b0001;
    tick();
    unit_done = 4'b0000;
    chk("t6_late_err", {30'd0, rif.res_err}, 32'd3);
    chk("t6_late_data", rif.res_data, 32'd0);
    rif.res_ready = 1'b1;
    wait_idle("t6");
    unit_done = 4'b0001;
    tick();
    unit_done = 4'b0000;
    chk("t6_idle_done_busy", {31'd0, busy}, 32'd0);
    chk("t6_idle_done_valid", {31'd0, rif.res_valid}, 32'd0);
`else
    // 6: without timeout support WAIT holds until done or reset.
    cmd(4'd2, 5'd1, 16'd5, 16'd5);
    for (int i = 0; i < 80; i++) tick();
    chk("t6_still_busy", {31'd0, busy}, 32'd1);
    chk("t6_no_valid", {31'd0, rif.res_valid}, 32'd0);
    pulse_reset("t6_rst");
`endif

    // 7: asynchronous reset in WAIT; a later done must not revive the operation.
    rif.res_ready = 1'b1;
    cmd(4'd1, 5'd3, 16'h0102, 16'h0304);
    for (int i = 0; i < 3; i++) tick();
    chk("t7_busy_before", {31'd0, busy}, 32'd1);
    pulse_reset("t7_rst");
    unit_done = 4'b0100;
    tick();
    unit_done = 4'b0000;
    chk("t7_busy_after", {31'd0, busy}, 32'd0);
    chk("t7_valid_after", {31'd0, rif.res_valid}, 32'd0);
    chk("t7_start_after", {28'd0, unit_start}, 32'd0);

    tick();
    tick();
    chk("sb_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
